// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths and
// the bit positions of the control bundle carried alongside the payload.
package ex_mem_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 5;

    // Control bundle layout {memToReg, memWrite, regWrite}
    localparam int CTL_REGWRITE = 0;
    localparam int CTL_MEMWRITE = 1;
    localparam int CTL_MEMTOREG = 2;
    localparam int CTL_W        = 3;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// Handshake and payload bundle between execute, the EX/MEM register and the
// memory stage. The slave modport is the register's view; master is the
// driver's view. Forwarding outputs exist only when EX_MEM_FWD_EN is defined.
interface ex_mem_pipe_if
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
);
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_alu;
    logic [DATA_W-1:0] i_data;
    logic [REG_W-1:0]  i_rd;
    logic              i_regWrite;
    logic              i_memWrite;
    logic              i_memToReg;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_alu;
    logic [DATA_W-1:0] o_data;
    logic [REG_W-1:0]  o_rd;
    logic              o_regWrite;
    logic              o_memWrite;
    logic              o_memToReg;
`ifdef EX_MEM_FWD_EN
    logic              o_fwd_valid;
    logic [REG_W-1:0]  o_fwd_rd;
    logic [DATA_W-1:0] o_fwd_val;
`endif

    modport slave (
        input  i_flush, i_valid, i_alu, i_data, i_rd,
               i_regWrite, i_memWrite, i_memToReg, i_ready,
`ifdef EX_MEM_FWD_EN
        output o_fwd_valid, o_fwd_rd, o_fwd_val,
`endif
        output o_ready, o_valid, o_alu, o_data, o_rd,
               o_regWrite, o_memWrite, o_memToReg
    );

    modport master (
        output i_flush, i_valid, i_alu, i_data, i_rd,
               i_regWrite, i_memWrite, i_memToReg, i_ready,
`ifdef EX_MEM_FWD_EN
        input  o_fwd_valid, o_fwd_rd, o_fwd_val,
`endif
        input  o_ready, o_valid, o_alu, o_data, o_rd,
               o_regWrite, o_memWrite, o_memToReg
    );

endinterface

// File: rtl/ex_mem_pipe_skid.sv
// Generic 2-entry valid/ready skid buffer with flush. The main entry drives
// the outputs; the skid entry absorbs one word when the consumer stalls, so
// o_ready depends only on registered state and never on i_ready.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept, consume;

    // Next-state: flush wins, then drain skid, else reload/park/clear main
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        accept       = i_valid & ~skid_valid_q;
        consume      = main_valid_q & i_ready;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (consume) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (consume && accept) begin
                main_data_d = i_data;
            end else if (consume) begin
                main_valid_d = 1'b0;
            end else if (accept) begin
                skid_data_d  = i_data;
                skid_valid_d = 1'b1;
            end
        end else if (accept) begin
            main_data_d  = i_data;
            main_valid_d = 1'b1;
        end
    end

    // State register; reset clears valid bits and payload
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign o_ready = ~skid_valid_q;
    assign o_valid = main_valid_q;
    assign o_data  = main_data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register. Packs {ctl, rd, data, alu} into a skid buffer and
// gates the control outputs with o_valid so bubbles never write RAM or the
// register file. Define EX_MEM_FWD_EN to add the EX bypass outputs.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ex_mem_pipe_if.slave  bus
);
    localparam int W = CTL_W + REG_W + 2 * DATA_W;

    logic [CTL_W-1:0]  in_ctl;
    logic [W-1:0]      in_word;
    logic [W-1:0]      out_word;
    logic              out_valid;
    logic [CTL_W-1:0]  out_ctl;
    logic [REG_W-1:0]  out_rd;
    logic [DATA_W-1:0] out_alu;

    // Pack the execute-side control bits and payload into one word
    always_comb begin
        in_ctl               = '0;
        in_ctl[CTL_REGWRITE] = bus.i_regWrite;
        in_ctl[CTL_MEMWRITE] = bus.i_memWrite;
        in_ctl[CTL_MEMTOREG] = bus.i_memToReg;
        in_word              = {in_ctl, bus.i_rd, bus.i_data, bus.i_alu};
    end

    pipe_skid_buf #(.W(W)) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (bus.i_flush),
        .i_valid (bus.i_valid),
        .o_ready (bus.o_ready),
        .i_data  (in_word),
        .o_valid (out_valid),
        .i_ready (bus.i_ready),
        .o_data  (out_word)
    );

    assign out_alu = out_word[DATA_W-1:0];
    assign out_rd  = out_word[2*DATA_W +: REG_W];
    assign out_ctl = out_word[W-1 -: CTL_W];

    assign bus.o_valid    = out_valid;
    assign bus.o_alu      = out_alu;
    assign bus.o_data     = out_word[DATA_W +: DATA_W];
    assign bus.o_rd       = out_rd;
    assign bus.o_regWrite = out_valid & out_ctl[CTL_REGWRITE];
    assign bus.o_memWrite = out_valid & out_ctl[CTL_MEMWRITE];
    assign bus.o_memToReg = out_valid & out_ctl[CTL_MEMTOREG];

`ifdef EX_MEM_FWD_EN
    // Loads are never forwarded; the hazard unit stalls on them instead
    assign bus.o_fwd_valid = out_valid & out_ctl[CTL_REGWRITE]
                           & ~out_ctl[CTL_MEMTOREG] & (out_rd != '0);
    assign bus.o_fwd_rd    = out_rd;
    assign bus.o_fwd_val   = out_alu;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Testbench for ex_mem_pipe: directed vector table, hand-written reset and
// forwarding sequences, then random traffic against an occupancy-queue model.
module tb_ex_mem_pipe;
    import ex_mem_pipe_pkg::*;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        m2r;
    } pay_t;

    typedef struct {
        logic        valid;
        logic        flush;
        logic        rdy;
        logic [31:0] alu;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_alu;
    } vec_t;

    logic i_clk;
    logic i_rst;
    int   checks;
    int   errors;

    pay_t model_q[$];
    pay_t cur_pay;
    logic cur_valid, cur_rdy, cur_flush;
    vec_t vecs[16];

    ex_mem_pipe_if bus ();

    ex_mem_pipe dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input pay_t p, input logic rdy, input logic fl);
        cur_valid      = v;
        cur_pay        = p;
        cur_rdy        = rdy;
        cur_flush      = fl;
        bus.i_valid    = v;
        bus.i_alu      = p.alu;
        bus.i_data     = p.data;
        bus.i_rd       = p.rd;
        bus.i_regWrite = p.rw;
        bus.i_memWrite = p.mw;
        bus.i_memToReg = p.m2r;
        bus.i_ready    = rdy;
        bus.i_flush    = fl;
    endtask

    task automatic check_output();
        logic exp_v;
        pay_t front;
        exp_v = (model_q.size() != 0);
        front = exp_v ? model_q[0] : '0;
        check("o_valid", bus.o_valid, exp_v);
        check("o_ready", bus.o_ready, model_q.size() < 2);
        check("o_regWrite", bus.o_regWrite, exp_v & front.rw);
        check("o_memWrite", bus.o_memWrite, exp_v & front.mw);
        check("o_memToReg", bus.o_memToReg, exp_v & front.m2r);
        if (exp_v) begin
            check("o_alu", bus.o_alu, front.alu);
            check("o_data", bus.o_data, front.data);
            check("o_rd", bus.o_rd, front.rd);
        end
`ifdef EX_MEM_FWD_EN
        check("o_fwd_valid", bus.o_fwd_valid, exp_v & front.rw & ~front.m2r & (front.rd != 0));
        if (exp_v) begin
            check("o_fwd_rd", bus.o_fwd_rd, front.rd);
            check("o_fwd_val", bus.o_fwd_val, front.alu);
        end
`endif
    endtask

    // Two-entry FIFO semantics: ready while fewer than two held, flush empties
    task automatic model_step();
        logic can_take, take, give;
        if (cur_flush) begin
            model_q.delete();
        end else begin
            can_take = (model_q.size() < 2);
            give     = (model_q.size() > 0) && cur_rdy;
            take     = cur_valid && can_take;
            if (give) void'(model_q.pop_front());
            if (take) model_q.push_back(cur_pay);
        end
    endtask

    task automatic run_cycle();
        @(negedge i_clk);
        check_output();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    function automatic pay_t mk_pay(input logic [31:0] alu, input logic [4:0] rd,
                                    input logic rw, input logic mw, input logic m2r);
        pay_t p;
        p.alu  = alu;
        p.data = ~alu;
        p.rd   = rd;
        p.rw   = rw;
        p.mw   = mw;
        p.m2r  = m2r;
        return p;
    endfunction

    initial begin
        checks = 0;
        errors = 0;

        // valid, flush, rdy, alu, exp_valid, exp_ready, exp_alu
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 32'h1};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 32'h2};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 32'h3};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 1'b0, 32'h10};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h30, 1'b1, 1'b0, 32'h10};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h20};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 1'b1, 32'h40};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h50, 1'b1, 1'b0, 32'h40};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h60, 1'b0, 1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'h70, 1'b0, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'h90, 1'b1, 1'b1, 32'h90};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0};

        // Power-on reset: everything zero, ready asserted
        i_rst = 1'b1;
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_o_valid", bus.o_valid, 1'b0);
        check("rst_o_ready", bus.o_ready, 1'b1);
        check("rst_o_alu", bus.o_alu, 32'h0);
        check("rst_o_memWrite", bus.o_memWrite, 1'b0);
        i_rst = 1'b0;
        $display("[TB] reset released");

        // Streaming, backpressure, flush and bubble vectors (memWrite=1 in every row)
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i].valid, mk_pay(vecs[i].alu, 5'd3, 1'b1, 1'b1, 1'b0),
                           vecs[i].rdy, vecs[i].flush);
            run_cycle();
            check($sformatf("vec%0d_valid", i), bus.o_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ready", i), bus.o_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_memWrite", i), bus.o_memWrite, vecs[i].exp_valid);
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_alu", i), bus.o_alu, vecs[i].exp_alu);
        end

        // Reset asserted mid-stall with both entries full
        apply_stimulus(1'b1, mk_pay(32'hA1, 5'd7, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);
        run_cycle();
        apply_stimulus(1'b1, mk_pay(32'hA2, 5'd8, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);
        run_cycle();
        check("stall_o_ready", bus.o_ready, 1'b0);
        apply_stimulus(1'b0, '0, 1'b0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        model_q.delete();
        check("midrst_o_valid", bus.o_valid, 1'b0);
        check("midrst_o_alu", bus.o_alu, 32'h0);
        check("midrst_o_data", bus.o_data, 32'h0);
        check("midrst_o_rd", bus.o_rd, 5'd0);
        check("midrst_o_regWrite", bus.o_regWrite, 1'b0);
        check("midrst_o_memWrite", bus.o_memWrite, 1'b0);
        check("midrst_o_memToReg", bus.o_memToReg, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("postrst_o_ready", bus.o_ready, 1'b1);
        check("postrst_o_valid", bus.o_valid, 1'b0);

`ifdef EX_MEM_FWD_EN
        // Forwarding: ALU writer forwards, rd=0 and loads do not
        apply_stimulus(1'b1, mk_pay(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
        run_cycle();
        check("fwd_alu_valid", bus.o_fwd_valid, 1'b1);
        check("fwd_alu_val", bus.o_fwd_val, 32'h1234);
        check("fwd_alu_rd", bus.o_fwd_rd, 5'd5);
        apply_stimulus(1'b1, mk_pay(32'h5678, 5'd0, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
        run_cycle();
        check("fwd_rd0_valid", bus.o_fwd_valid, 1'b0);
        apply_stimulus(1'b1, mk_pay(32'h9abc, 5'd6, 1'b1, 1'b0, 1'b1), 1'b1, 1'b0);
        run_cycle();
        check("fwd_load_valid", bus.o_fwd_valid, 1'b0);
`endif

        // Random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            pay_t p;
            p.alu  = $urandom;
            p.data = $urandom;
            p.rd   = 5'($urandom_range(0, 31));
            p.rw   = 1'($urandom_range(0, 1));
            p.mw   = 1'($urandom_range(0, 1));
            p.m2r  = 1'($urandom_range(0, 1));
            apply_stimulus(($urandom % 4) != 0, p, ($urandom % 3) != 0, ($urandom % 16) == 0);
            run_cycle();
        end
        apply_stimulus(1'b0, '0, 1'b1, 1'b0);
        repeat (3) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
